// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - EX/SRAM to MEM to WB/ID bus bundle for the MEM stage
interface mem_stage_if #(
  parameter int EX_TO_MEM_WD = 79,
  parameter int MEM_TO_WB_WD = 70,
  parameter int MEM_TO_RF_WD = 38
);
  logic [5:0]              stall;
  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
  logic [31:0]             data_sram_rdata;
  logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus;
  logic [MEM_TO_RF_WD-1:0] mem_to_rf_bus;

  modport master (
    output stall,
    output ex_to_mem_bus,
    output data_sram_rdata,
    input  mem_to_wb_bus,
    input  mem_to_rf_bus
  );

  modport slave (
    input  stall,
    input  ex_to_mem_bus,
    input  data_sram_rdata,
    output mem_to_wb_bus,
    output mem_to_rf_bus
  );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: load extraction, WB/forward buses; optional MEM_RDATA_HOLD_EN read-data hold
module mem_stage (
  input  logic        clk,
  input  logic        resetn,
  mem_stage_if.slave  bus
);
  localparam int EX_TO_MEM_WD = 79;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LBU = 3'b010;
  localparam logic [2:0] OP_LH  = 3'b011;
  localparam logic [2:0] OP_LHU = 3'b100;

  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus_r;

  logic [31:0] pc;
  logic [2:0]  load_op;
  logic        data_ram_en;
  logic [3:0]  data_ram_wen;
  logic        sel_rf_res;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] ex_result;

  logic        mem_stop;
  logic        wb_stop;
  logic        bubble;
  logic        load_en;
  logic        unused_stall;

  logic [31:0] rdata_src;
  logic [7:0]  byte_data;
  logic [15:0] half_data;
  logic [31:0] load_data;
  logic [31:0] rf_wdata;

  assign {pc, load_op, data_ram_en, data_ram_wen, sel_rf_res,
          rf_we, rf_waddr, ex_result} = ex_to_mem_bus_r;

  assign mem_stop     = bus.stall[3];
  assign wb_stop      = bus.stall[4];
  assign bubble       = mem_stop & ~wb_stop;
  assign load_en      = ~mem_stop;
  assign unused_stall = ^{bus.stall[5], bus.stall[2:0]};

  // Bubble outranks load; both stopped means the register holds.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ex_to_mem_bus_r <= '0;
    end else if (bubble) begin
      ex_to_mem_bus_r <= '0;
    end else if (load_en) begin
      ex_to_mem_bus_r <= bus.ex_to_mem_bus;
    end
  end

`ifdef MEM_RDATA_HOLD_EN
  logic        is_load;
  logic        hold_vld;
  logic [31:0] rdata_hold;

  assign is_load = data_ram_en & (data_ram_wen == 4'b0000) & sel_rf_res;

  // SRAM data is only guaranteed for one cycle; freeze it at the first stalled edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_vld   <= 1'b0;
      rdata_hold <= '0;
    end else if (bubble || load_en) begin
      hold_vld   <= 1'b0;
    end else if (!hold_vld && is_load) begin
      hold_vld   <= 1'b1;
      rdata_hold <= bus.data_sram_rdata;
    end
  end

  assign rdata_src = hold_vld ? rdata_hold : bus.data_sram_rdata;
`else
  assign rdata_src = bus.data_sram_rdata;
`endif

  always_comb begin
    byte_data = rdata_src[7:0];
    case (ex_result[1:0])
      2'b00:   byte_data = rdata_src[7:0];
      2'b01:   byte_data = rdata_src[15:8];
      2'b10:   byte_data = rdata_src[23:16];
      default: byte_data = rdata_src[31:24];
    endcase
  end

  // ex_result[0] is deliberately ignored for halfwords: no alignment trap.
  assign half_data = ex_result[1] ? rdata_src[31:16] : rdata_src[15:0];

  always_comb begin
    load_data = rdata_src;
    case (load_op)
      OP_LW:   load_data = rdata_src;
      OP_LB:   load_data = {{24{byte_data[7]}}, byte_data};
      OP_LBU:  load_data = {24'h000000, byte_data};
      OP_LH:   load_data = {{16{half_data[15]}}, half_data};
      OP_LHU:  load_data = {16'h0000, half_data};
      default: load_data = rdata_src;
    endcase
  end

  assign rf_wdata = sel_rf_res ? load_data : ex_result;

  assign bus.mem_to_wb_bus = {pc, rf_we, rf_waddr, rf_wdata};
  assign bus.mem_to_rf_bus = {rf_we, rf_waddr, rf_wdata};
endmodule
